// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the two requester ports (I fetch, D load/store) and the
// single-port RAM side of mem_port_arbiter.
//   slave  modport : arbiter view (requests and RAM read data in; readies, read data,
//                    RAM address/strobes out)
//   master modport : requester/RAM view, the mirror image of slave
// Parameters: AW byte-address width of the requester ports, MEM_AW RAM word-address width.
interface mem_port_arbiter_if #(
  parameter int unsigned AW     = 32,
  parameter int unsigned MEM_AW = AW - 2
);
  // I port (read only)
  logic              i_req;
  logic [AW-1:0]     i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  // D port (read or masked write)
  logic              d_req;
  logic [AW-1:0]     d_addr;
  logic [3:0]        d_wmask;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  // RAM side
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rstrb;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, mem_rdata,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wmask, d_wdata, mem_rdata,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_addr, mem_rstrb, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous word RAM (1-cycle read latency)
// between the instruction-fetch port (I) and the load/store port (D).
// Ports:
//   CLK     system clock, all state on posedge
//   resetn  asynchronous active-low reset
//   bus     mem_port_arbiter_if.slave: I/D request/ready/rvalid/rdata and RAM
//           addr/rstrb/wmask/wdata/rdata
// A grant is made combinationally in IDLE. Reads move to RD_WAIT for one cycle while the
// RAM produces data, which is captured into the owner's rdata register; rvalid pulses the
// cycle after. Writes complete in the grant cycle, so they can issue every cycle.
// Configuration: define MEMARB_RR_EN for round-robin arbitration on contention; otherwise
// D has fixed priority over I.
module mem_port_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned MEM_AW = 30
) (
  input logic               CLK,
  input logic               resetn,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;   // read owner: 1 = D, 0 = I
  logic              gnt_i, gnt_d;
  logic              d_is_rd;
  logic              issue_rd;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       i_rdata_q, d_rdata_q;
  logic              i_rvalid_q, d_rvalid_q;

  // Byte-offset bits of the requester addresses are meaningless for a word RAM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  assign d_is_rd = (bus.d_wmask == 4'b0000);

`ifdef MEMARB_RR_EN
  // 1 = D favoured on the next contended grant.
  logic ptr_q, ptr_d;
  logic contend;

  assign contend = (state_q == StIdle) && bus.i_req && bus.d_req;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == StIdle) begin
      gnt_d = bus.d_req && (!bus.i_req || ptr_q);
      gnt_i = bus.i_req && (!bus.d_req || !ptr_q);
    end
  end

  // Only contended grants move the pointer, and it always points away from the winner.
  always_comb begin
    ptr_d = ptr_q;
    if (contend) begin
      ptr_d = gnt_i;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == StIdle) begin
      gnt_d = bus.d_req;
      gnt_i = bus.i_req && !bus.d_req;
    end
  end
`endif

  assign issue_rd = gnt_i || (gnt_d && d_is_rd);

  // State register
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      StIdle: begin
        if (issue_rd) begin
          state_d = StRdWait;
          owner_d = gnt_d;
        end
      end
      StRdWait: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Address and write data hold their last issued value while nothing is granted.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (gnt_d) begin
      addr_d  = bus.d_addr[AW-1:2];
      wdata_d = bus.d_wdata;
    end else if (gnt_i) begin
      addr_d  = bus.i_addr[AW-1:2];
    end
  end

  // Output logic
  always_comb begin
    bus.i_ready   = gnt_i;
    bus.d_ready   = gnt_d;
    bus.mem_rstrb = issue_rd;
    bus.mem_wmask = (gnt_d && !d_is_rd) ? bus.d_wmask : 4'b0000;
    bus.mem_addr  = addr_d;
    bus.mem_wdata = wdata_d;
    bus.i_rvalid  = i_rvalid_q;
    bus.d_rvalid  = d_rvalid_q;
    bus.i_rdata   = i_rdata_q;
    bus.d_rdata   = d_rdata_q;
  end

  // Read-data capture; an async reset during RD_WAIT drops the read.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rvalid_q <= (state_q == StRdWait) && !owner_q;
      d_rvalid_q <= (state_q == StRdWait) && owner_q;
      if (state_q == StRdWait) begin
        if (owner_q) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          i_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

endmodule
